// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary-to-BCD converter
//
// Converts one unsigned binary value into packed BCD digits, one input bit
// per clock, behind valid/ready handshakes on both sides. Feeds bcd7seg
// digit decoders, one nibble per decoder.
//
// Parameters
//   BIN_W      width of the binary input (>= 1)
//   DIGITS     number of BCD digits produced (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_bin holds a value to convert
//   in_ready   converter can accept a value (high only while idle)
//   in_bin     binary value, unsigned, BIN_W bits
//   out_valid  out_bcd/out_ovf hold a finished result
//   out_ready  consumer takes the result
//   out_bcd    packed BCD, [3:0] = ones, [7:4] = tens, ...
//   out_ovf    value exceeded 10^DIGITS-1; out_bcd is then meaningless

module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int SR_W  = ACC_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    // {BCD accumulator, remaining binary bits}; the binary part drains out
    // of the top while the accumulator fills from below.
    logic [SR_W-1:0]  sr;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;

    logic [ACC_W-1:0] acc_adj;
    logic [SR_W-1:0]  sr_adj;
    logic [SR_W-1:0]  sr_next;
    logic             ovf_next;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Add-3 correction on every digit >= 5, in parallel, strictly 4-bit:
    // digits never carry into each other, so a corrupted top digit can only
    // be detected by what falls off its MSB on the following shift.
    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[BIN_W + 4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
            end else begin
                acc_adj[4*i +: 4] = sr[BIN_W + 4*i +: 4];
            end
        end
        sr_adj   = {acc_adj, sr[BIN_W-1:0]};
        sr_next  = {sr_adj[SR_W-2:0], 1'b0};
        // Any 1 leaving the top digit would have belonged to a digit we do
        // not have, so the value does not fit; sticky until next acceptance.
        ovf_next = ovf_acc | sr_adj[SR_W-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sr      <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            out_bcd <= '0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sr      <= {{ACC_W{1'b0}}, in_bin};
                        ovf_acc <= 1'b0;
                        cnt     <= CNT_W'(BIN_W);
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sr      <= sr_next;
                    ovf_acc <= ovf_next;
                    cnt     <= cnt - CNT_W'(1);
                    // The published result only moves on the final shift so
                    // the previous result stays visible during a conversion.
                    if (cnt == CNT_W'(1)) begin
                        state   <= S_DONE;
                        out_bcd <= sr_next[SR_W-1:BIN_W];
                        out_ovf <= ovf_next;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
